// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with two combinational read ports,
// a writeback port, a JAL link-register port and a per-register pending
// scoreboard that drives a decode stall.
// Optional feature macro: REG_BYPASS_EN
//   defined   -> reads and Stall see this cycle's writes/clears
//   undefined -> reads and Stall see registered state only
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31  // must be non-zero and below 1<<ADDR_W
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic [ADDR_W-1:0]        ReadAddr1,
  input  logic [ADDR_W-1:0]        ReadAddr2,
  output logic [DATA_W-1:0]        RegBusA,
  output logic [DATA_W-1:0]        RegBusB,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteAddr,
  input  logic [DATA_W-1:0]        WBData,
  input  logic                     JAL,
  input  logic [DATA_W-1:0]        pcadd4,
  input  logic                     Issue,
  input  logic [ADDR_W-1:0]        IssueAddr,
  output logic                     Stall,
  output logic [(1<<ADDR_W)-1:0]   PendingMask
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_reg [NREGS];
  logic [DATA_W-1:0] wr_data  [NREGS];
  logic [NREGS-1:0]  pending_reg;
  logic [NREGS-1:0]  pending_next;
  logic [NREGS-1:0]  wb_hit;
  logic [NREGS-1:0]  jal_hit;
  logic [NREGS-1:0]  issue_hit;
  logic [NREGS-1:0]  wr_en;
  logic [NREGS-1:0]  stall_mask;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // Per-register decode of this cycle's writes, clears and sets.
  // Register 0 never matches any port, so it stays zero and never pends.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      assign wb_hit[gi]    = RegWrite && (WriteAddr == ADDR_W'(gi)) && (gi != 0);
      assign jal_hit[gi]   = JAL && (gi == LINK_REG);
      assign issue_hit[gi] = Issue && (IssueAddr == ADDR_W'(gi)) && (gi != 0);
      assign wr_en[gi]     = wb_hit[gi] || jal_hit[gi];
      // JAL wins when both ports target the link register.
      assign wr_data[gi]   = jal_hit[gi] ? pcadd4 : WBData;
      // Clears first, then set: a new producer supersedes a retiring one.
      assign pending_next[gi] = issue_hit[gi] ||
                                (pending_reg[gi] && !wb_hit[gi] && !jal_hit[gi]);
    end
  endgenerate

  // Register array: cleared on reset, written at posedge by either port.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en[i]) regs_reg[i] <= wr_data[i];
      end
    end
  end

  // Scoreboard pending bits.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) pending_reg <= '0;
    else        pending_reg <= pending_next;
  end

  // Read data and stall source, with or without same-cycle forwarding.
  always_comb begin
    rd_a       = regs_reg[ReadAddr1];
    rd_b       = regs_reg[ReadAddr2];
    stall_mask = pending_reg;
`ifdef REG_BYPASS_EN
    if (wr_en[ReadAddr1]) rd_a = wr_data[ReadAddr1];
    if (wr_en[ReadAddr2]) rd_b = wr_data[ReadAddr2];
    // A bit retiring this cycle no longer stalls unless re-issued now.
    stall_mask = pending_reg & ~((wb_hit | jal_hit) & ~issue_hit);
`endif
  end

  // Output drive: r0 always reads zero and never stalls.
  always_comb begin
    RegBusA     = (ReadAddr1 == '0) ? '0 : rd_a;
    RegBusB     = (ReadAddr2 == '0) ? '0 : rd_b;
    Stall       = ((ReadAddr1 != '0) && stall_mask[ReadAddr1]) ||
                  ((ReadAddr2 != '0) && stall_mask[ReadAddr2]);
    PendingMask = pending_reg;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed stimulus with a scoreboard queue. Stimulus drives
// inputs just after a posedge and queues expected outputs; a monitor pops and
// compares them on the following negedge.
module tb_reg_file_sb;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [4:0]  ReadAddr1, ReadAddr2, WriteAddr, IssueAddr;
  logic [31:0] RegBusA, RegBusB, WBData, pcadd4, PendingMask;
  logic        RegWrite, JAL, Issue, Stall;

  logic [2:0]  s_ra1, s_ra2, s_wa, s_ia;
  logic [15:0] s_busa, s_busb, s_wbd, s_pc;
  logic [7:0]  s_mask;
  logic        s_rw, s_jal, s_iss, s_stall;

  always #5 CLK = ~CLK;

  reg_file_sb dut (
    .CLK(CLK), .RST_n(RST_n),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .RegBusA(RegBusA), .RegBusB(RegBusB),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WBData(WBData),
    .JAL(JAL), .pcadd4(pcadd4),
    .Issue(Issue), .IssueAddr(IssueAddr),
    .Stall(Stall), .PendingMask(PendingMask)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .LINK_REG(7)) dut_s (
    .CLK(CLK), .RST_n(RST_n),
    .ReadAddr1(s_ra1), .ReadAddr2(s_ra2),
    .RegBusA(s_busa), .RegBusB(s_busb),
    .RegWrite(s_rw), .WriteAddr(s_wa), .WBData(s_wbd),
    .JAL(s_jal), .pcadd4(s_pc),
    .Issue(s_iss), .IssueAddr(s_ia),
    .Stall(s_stall), .PendingMask(s_mask)
  );

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      0: return RegBusA;
      1: return RegBusB;
      2: return {31'b0, Stall};
      3: return PendingMask;
      4: return {16'b0, s_busa};
      5: return {24'b0, s_mask};
      6: return {31'b0, s_stall};
      default: return 'x;
    endcase
  endfunction

  // Monitor: compare every queued expectation against live outputs.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge CLK);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = actual(e.kind);
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h want %h", e.name, act, e.val);
        end else begin
          $display("ok   %s: got %h", e.name, act);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_(input int kind, input logic [31:0] val, input string name);
    q.push_back('{kind, val, name});
  endtask

  task automatic clr();
    RegWrite = 1'b0; JAL = 1'b0; Issue = 1'b0;
  endtask

  function automatic logic [15:0] sval(input int i);
    return 16'(i * 16'h1000 + i);
  endfunction

  initial begin
    RST_n = 1'b0;
    ReadAddr1 = '0; ReadAddr2 = '0; WriteAddr = '0; IssueAddr = '0;
    WBData = '0; pcadd4 = '0; clr();
    s_ra1 = '0; s_ra2 = '0; s_wa = '0; s_ia = '0; s_wbd = '0; s_pc = '0;
    s_rw = 1'b0; s_jal = 1'b0; s_iss = 1'b0;

    // Reset state
    tick();
    exp_(0, 32'h0, "rst_busa"); exp_(2, 32'h0, "rst_stall");
    exp_(3, 32'h0, "rst_mask"); exp_(5, 32'h0, "rst_smask");
    tick(); RST_n = 1'b1;

    // T1: async reset with no clock edge
    tick(); RegWrite = 1'b1; WriteAddr = 5'd5; WBData = 32'h1234; Issue = 1'b1; IssueAddr = 5'd9;
    tick(); clr(); ReadAddr1 = 5'd5;
    exp_(0, 32'h1234, "t1_rd5"); exp_(3, 32'h200, "t1_mask9");
    tick(); RST_n = 1'b0;
    exp_(0, 32'h0, "t1_async_busa"); exp_(3, 32'h0, "t1_async_mask");
    tick(); RST_n = 1'b1;

    // T2: r0 is read-only zero and never pends
    tick(); RegWrite = 1'b1; WriteAddr = 5'd0; WBData = 32'hFFFF_FFFF;
    Issue = 1'b1; IssueAddr = 5'd0; ReadAddr1 = 5'd0;
    tick(); clr();
    exp_(0, 32'h0, "t2_r0"); exp_(3, 32'h0, "t2_mask"); exp_(2, 32'h0, "t2_stall");

    // T3: JAL beats writeback on the link register
    tick(); JAL = 1'b1; pcadd4 = 32'h40; RegWrite = 1'b1; WriteAddr = 5'd31; WBData = 32'h99;
    ReadAddr1 = 5'd31;
    exp_(0, BYP ? 32'h40 : 32'h0, "t3_same_cycle");
    tick(); clr();
    exp_(0, 32'h40, "t3_r31");
    tick(); JAL = 1'b1; pcadd4 = 32'h80; RegWrite = 1'b1; WriteAddr = 5'd4; WBData = 32'h44;
    ReadAddr1 = 5'd0;
    tick(); clr(); ReadAddr1 = 5'd31; ReadAddr2 = 5'd4;
    exp_(0, 32'h80, "t3_dual_r31"); exp_(1, 32'h44, "t3_dual_r4");

    // T4: scoreboard set/clear
    tick(); Issue = 1'b1; IssueAddr = 5'd7; ReadAddr1 = 5'd0; ReadAddr2 = 5'd0;
    tick(); clr(); ReadAddr1 = 5'd7;
    exp_(2, 32'h1, "t4_stall_set"); exp_(3, 32'h80, "t4_mask7");
    tick(); RegWrite = 1'b1; WriteAddr = 5'd7; WBData = 32'hAB; ReadAddr1 = 5'd0;
    tick(); clr(); ReadAddr1 = 5'd7;
    exp_(2, 32'h0, "t4_stall_clr"); exp_(0, 32'hAB, "t4_r7"); exp_(3, 32'h0, "t4_mask_clr");
    tick(); Issue = 1'b1; IssueAddr = 5'd7; RegWrite = 1'b1; WriteAddr = 5'd7; WBData = 32'hCD;
    ReadAddr1 = 5'd0;
    tick(); clr(); ReadAddr1 = 5'd7;
    exp_(3, 32'h80, "t4_set_beats_clr"); exp_(2, 32'h1, "t4_stall_again"); exp_(0, 32'hCD, "t4_r7b");
    tick(); Issue = 1'b1; IssueAddr = 5'd31; ReadAddr1 = 5'd0;
    tick(); clr(); JAL = 1'b1; pcadd4 = 32'h100;
    exp_(3, 32'h8000_0080, "t4_mask_7_31"); exp_(2, 32'h0, "t4_stall_r0");
    tick(); clr(); ReadAddr2 = 5'd31;
    exp_(3, 32'h80, "t4_jal_clr"); exp_(1, 32'h100, "t4_r31"); exp_(2, 32'h0, "t4_stall_31");
    tick(); RegWrite = 1'b1; WriteAddr = 5'd7; WBData = 32'hEE; ReadAddr2 = 5'd0;
    tick(); clr();
    exp_(3, 32'h0, "t4_mask_empty");

    // T5: same-cycle writeback vs read, and repeated issue
    tick(); RegWrite = 1'b1; WriteAddr = 5'd3; WBData = 32'h11;
    tick(); clr(); Issue = 1'b1; IssueAddr = 5'd3;
    tick(); Issue = 1'b1; IssueAddr = 5'd3;
    tick(); clr(); ReadAddr2 = 5'd3;
    exp_(3, 32'h8, "t5_double_issue"); exp_(2, 32'h1, "t5_stall"); exp_(1, 32'h11, "t5_r3");
    tick(); RegWrite = 1'b1; WriteAddr = 5'd3; WBData = 32'h55;
    exp_(1, BYP ? 32'h55 : 32'h11, "t5_byp_data"); exp_(2, BYP ? 32'h0 : 32'h1, "t5_byp_stall");
    tick(); clr();
    exp_(1, 32'h55, "t5_r3_new"); exp_(2, 32'h0, "t5_stall_done"); exp_(3, 32'h0, "t5_mask");
    tick(); Issue = 1'b1; IssueAddr = 5'd3;
    tick(); clr(); Issue = 1'b1; IssueAddr = 5'd3; RegWrite = 1'b1; WriteAddr = 5'd3; WBData = 32'h66;
    exp_(2, 32'h1, "t5_reissue_stall"); exp_(1, BYP ? 32'h66 : 32'h55, "t5_reissue_data");
    tick(); clr();
    exp_(3, 32'h8, "t5_reissue_mask"); exp_(1, 32'h66, "t5_r3_66");
    tick(); RegWrite = 1'b1; WriteAddr = 5'd3; WBData = 32'h0;
    tick(); clr();

    // T6: 16-bit x 8 instance
    for (int i = 0; i < 8; i++) begin
      tick(); s_rw = 1'b1; s_wa = 3'(i); s_wbd = (i == 0) ? 16'hFFFF : sval(i);
    end
    tick(); s_rw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(); s_ra1 = 3'(i);
      exp_(4, {16'b0, (i == 0) ? 16'h0 : sval(i)}, $sformatf("t6_rd%0d", i));
    end
    tick(); s_jal = 1'b1; s_pc = 16'hBEEF; s_ra1 = 3'd0;
    tick(); s_jal = 1'b0; s_ra1 = 3'd7;
    exp_(4, 32'hBEEF, "t6_jal_r7");
    tick(); s_iss = 1'b1; s_ia = 3'd2; s_ra1 = 3'd0;
    tick(); s_ia = 3'd7;
    tick(); s_iss = 1'b0; s_ra1 = 3'd2;
    exp_(5, 32'h84, "t6_mask"); exp_(6, 32'h1, "t6_stall");
    tick(); s_jal = 1'b1; s_pc = 16'h0001; s_ra1 = 3'd0;
    tick(); s_jal = 1'b0;
    exp_(5, 32'h04, "t6_jal_clr");

    tick(); tick();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d want 0 pending expectations", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
